// File: rtl/mini_pkg.sv
// Shared MiniMicro definitions: instruction field layout, opcodes and fetch FSM states.
package mini_pkg;

  localparam int unsigned OpcodeW   = 2;
  localparam int unsigned RegW      = 2;
  localparam int unsigned OpcodeLsb = 6;
  localparam int unsigned RdLsb     = 4;
  localparam int unsigned Rs1Lsb    = 2;
  localparam int unsigned Rs2Lsb    = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_JMP = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StLatch = 2'b01,
    StValid = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of an 8-bit MiniMicro instruction into its fields.
module instr_decode
  import mini_pkg::*;
(
  input  logic [7:0] instr_i,
  output logic [1:0] opcode_o,
  output logic [1:0] rd_o,
  output logic [1:0] rs1_o,
  output logic [1:0] rs2_o
);

  opcode_e op;

  assign op       = opcode_e'(instr_i[OpcodeLsb +: OpcodeW]);
  assign opcode_o = op;
  assign rd_o     = instr_i[RdLsb +: RegW];
  assign rs1_o    = instr_i[Rs1Lsb +: RegW];
  assign rs2_o    = instr_i[Rs2Lsb +: RegW];

endmodule

// File: rtl/instr_fetch.sv
// MiniMicro fetch stage: drives program memory, latches the returned instruction and
// hands it to execute over a valid/ready handshake; execute may redirect the PC.
module instr_fetch
  import mini_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned RESET_PC  = 0,
  localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [AW-1:0]     redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [AW-1:0]     instr_pc,
  output logic [1:0]        opcode,
  output logic [1:0]        rd,
  output logic [1:0]        rs1,
  output logic [1:0]        rs2
);

  localparam logic [AW-1:0] LastPc  = AW'(MEM_DEPTH - 1);
  // Wraps to zero for power-of-two depths, where the reduction branch is unreachable.
  localparam logic [AW-1:0] DepthAw = AW'(MEM_DEPTH);
  localparam logic [AW-1:0] ResetPc = AW'(RESET_PC);

  fetch_state_e      state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [AW-1:0]     instr_pc_q, instr_pc_d;
  logic [AW-1:0]     pc_inc;
  logic [AW-1:0]     redirect_pc_mod;

  // An AW-bit target is below 2*MEM_DEPTH, so one subtraction is a full modulo.
  assign redirect_pc_mod = (redirect_pc > LastPc) ? redirect_pc - DepthAw : redirect_pc;
  assign pc_inc          = (pc_q == LastPc) ? '0 : pc_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    if (redirect_valid) begin
      // Redirect wins; a simultaneous handshake is consumed without the +1.
      pc_d    = redirect_pc_mod;
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (fetch_en) state_d = StLatch;
        end
        StLatch: begin
          instr_d    = mem_rdata;
          instr_pc_d = pc_q;
          state_d    = StValid;
        end
        StValid: begin
          if (instr_ready) begin
            pc_d    = pc_inc;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= ResetPc;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_addr    = pc_q;
  assign mem_we      = 1'b1;
  assign instr_valid = (state_q == StValid);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  instr_decode u_decode (
    .instr_i  (instr_q),
    .opcode_o (opcode),
    .rd_o     (rd),
    .rs1_o    (rs1),
    .rs2_o    (rs2)
  );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the MiniMicro core. Sits directly upstream of the program memory: drives its address and read-mode strobe, captures the returned 8-bit instruction into an instruction register, and splits it into fields. Presents the instruction to the execute stage with a valid/ready handshake. Accepts a PC redirect from execute for jumps.

## Interface

- `DATA_W`, 8: instruction/memory word width.
- `MEM_DEPTH`, 64: program memory locations; `AW = $clog2(MEM_DEPTH)`.
- `RESET_PC`, 0: PC value loaded on reset.

- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `fetch_en`, in, 1: permits a new fetch to start.
- `mem_addr`, out, AW: program memory address; always equals the PC register.
- `mem_we`, out, 1: memory mode strobe; memory reads on 1 and writes on 0. Tied to 1.
- `mem_rdata`, in, DATA_W: memory read data, registered in memory, one-cycle latency.
- `redirect_valid`, in, 1: load a new PC, from a jump.
- `redirect_pc`, in, AW: target PC.
- `instr_valid`, out, 1: instruction outputs are valid.
- `instr_ready`, in, 1: execute accepts the instruction.
- `instr`, out, DATA_W: raw instruction register.
- `instr_pc`, out, AW: address the instruction was fetched from.
- `opcode`, out, 2: `instr[7:6]`.
- `rd`, out, 2: `instr[5:4]`.
- `rs1`, out, 2: `instr[3:2]`.
- `rs2`, out, 2: `instr[1:0]`.

## Operation

- The FSM has three states: FETCH, LATCH and VALID.
- **FETCH**: PC is on `mem_addr`. If `fetch_en` is 1, go to LATCH; otherwise stay. The memory samples the address on this edge.
- **LATCH**: `mem_rdata` now holds `mem[pc]`. On the edge, `instr <= mem_rdata`, `instr_pc <= pc`, then go to VALID.
- **VALID**: `instr_valid` is 1. On `instr_valid && instr_ready`: `pc <= pc + 1`, then go to FETCH.
- **PC wrap**: the increment wraps `MEM_DEPTH-1 -> 0`. Compute it modulo `MEM_DEPTH`, not modulo `2^AW`, when `MEM_DEPTH` is not a power of two.
- **Redirect**: `redirect_valid` in any state sets `pc <= redirect_pc` and state to FETCH. `instr_valid` drops the next cycle.
- **Redirect with handshake in the same cycle**: the handshaked instruction counts as consumed, and redirect sets the PC (no `+1`).
- `redirect_pc >= MEM_DEPTH` is reduced modulo `MEM_DEPTH`.
- In VALID, `instr` and all field outputs stay stable until the handshake or a redirect.
- The field outputs are combinational slices of `instr`.

## Timing

- **Reset values** (asynchronous, effective immediately):
  - PC: `RESET_PC`
  - `mem_addr`: `RESET_PC`
  - state: FETCH
  - `instr_valid`: 0
  - `instr`: 0, so all fields read 0
  - `instr_pc`: 0
  - `mem_we`: 1
- **Latency**: fetch start to `instr_valid` is 2 edges. Minimum issue interval is 3 cycles per instruction, reached when `instr_ready` is held at 1.
- **Reset mid-operation**: abandons any fetch in flight, and no stale `mem_rdata` is ever latched. The memory's `rdata` is not reset, so the value captured in LATCH is the only trusted one.
- **`fetch_en` low**: only gates the FETCH->LATCH transition. A fetch already in LATCH or VALID completes.

## Structure

- A shared package `mini_pkg` holds:
  - field widths and bit positions;
  - the opcode enum: `OP_ADD=2'b00`, `OP_SUB=2'b01`, `OP_AND=2'b10`, `OP_JMP=2'b11`;
  - the fetch state enum.
- One combinational sub-module, `instr_decode`, maps `instr` to `opcode`/`rd`/`rs1`/`rs2`. Execute reuses it.

## Test plan

- **Reset to first instruction**: `mem[0]=8'h37`, release `rst`, hold `instr_ready=0`.
  - `instr_valid` rises 2 edges after the first post-reset edge.
  - Outputs: `instr=8'h37`, `opcode=ADD`, `rd=3`, `rs1=1`, `rs2=3`, `instr_pc=0`.
  - The outputs hold for 10 cycles.
- **Streaming**: `mem[0..3]={8'h37,8'h4E,8'h91,8'hC5}`, `instr_ready=1`.
  - Four instructions, one every 3 cycles.
  - `instr_pc` sequence 0,1,2,3.
- **Wrap**: `redirect_pc=63`, then accept.
  - Next `instr_pc=0`, with `mem_addr` going `63->0`.
- **Redirect racing handshake**: in VALID, `instr_ready=1` and `redirect_valid=1` with `redirect_pc=10` in the same cycle.
  - One accepted handshake.
  - Next `instr_pc=10`, not `pc+1`.
- **`fetch_en` gating**: `fetch_en=0` after reset for 5 cycles.
  - `mem_addr` stays at `RESET_PC` and `instr_valid` stays 0.
  - Raising `fetch_en` gives `instr_valid` 2 edges later.
- **Reset mid-fetch**: assert `rst` while in LATCH.
  - Same cycle: `instr_valid=0`, `instr=0`, `mem_addr=RESET_PC`.
  - After release, the instruction at `RESET_PC` is delivered correctly.
